// File: rtl/load_store_master.sv
// Load/store bus master: decodes a pipeline access, drives one memory request,
// waits for the responder's ack (with timeout) and returns the extended load data.
`ifndef LTYPE
`define LTYPE 5'b00000
`endif
`ifndef STYPE
`define STYPE 5'b01000
`endif

module load_store_master #(
    parameter int unsigned TIMEOUT    = 16,
    parameter logic [4:0]  LTYPE_CODE = `LTYPE,
    parameter logic [4:0]  STYPE_CODE = `STYPE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [4:0]  itype_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned   CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          mis_q, mis_d;
    logic          fault_q, fault_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    lo_q, lo_d;

    logic          is_load, is_store, f3_legal, misaligned;
    logic [3:0]    be_calc;
    logic [31:0]   wdata_calc, load_shift, load_ext;

    // Request decode, evaluated only when an access is launched from IDLE.
    always_comb begin
        is_load  = (itype_i == LTYPE_CODE);
        is_store = !is_load && (itype_i == STYPE_CODE);
        f3_legal = 1'b0;
        if (is_load) begin
            f3_legal = funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        end else if (is_store) begin
            f3_legal = funct3_i inside {3'd0, 3'd1, 3'd2};
        end
        misaligned = ((funct3_i[1:0] == 2'd1) && addr_i[0]) ||
                     ((funct3_i[1:0] == 2'd2) && (addr_i[1:0] != 2'b00));
        case (funct3_i[1:0])
            2'd0: begin
                be_calc    = 4'b0001 << addr_i[1:0];
                wdata_calc = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                be_calc    = 4'b0011 << addr_i[1:0];
                wdata_calc = {2{wdata_i[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata_i;
            end
        endcase
    end

    // Lane extraction uses the byte offset captured at launch.
    always_comb begin
        load_shift = mem_rdata_i >> {lo_q, 3'b000};
        case (f3_q)
            3'd0:    load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
            3'd4:    load_ext = {24'b0, load_shift[7:0]};
            3'd1:    load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
            3'd5:    load_ext = {16'b0, load_shift[15:0]};
            default: load_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        fault_d = 1'b0;
        rdata_d = rdata_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && (is_load || is_store)) begin
                    f3_d = funct3_i;
                    lo_d = addr_i[1:0];
                    if (!f3_legal || misaligned) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fault_d = !f3_legal;
                        mis_d   = f3_legal;
                        rdata_d = '0;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {addr_i[31:2], 2'b00};
                        be_d    = be_calc;
                        wdata_d = is_store ? wdata_calc : '0;
                    end
                end
            end
            S_REQ: begin
                // An ack on the last allowed cycle takes priority over the timeout.
                if (mem_ack_i || (cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fault_d = !mem_ack_i;
                    rdata_d = (mem_ack_i && !we_q) ? load_ext : '0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    be_d    = '0;
                    wdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign misalign_o  = mis_q;
    assign fault_o     = fault_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_master.sv
// Bench for load_store_master: transaction-level expectations checked every cycle,
// directed scenarios with literal results, then randomized accesses.
module tb_load_store_master;

    localparam int         TO     = 16;
    localparam logic [4:0] L_CODE = 5'b00000;
    localparam logic [4:0] S_CODE = 5'b01000;

    logic        clk, reset;
    logic        start_i;
    logic [4:0]  itype_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        busy_o, done_o, misalign_o, fault_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  dbg_state_o;

    load_store_master #(
        .TIMEOUT(TO), .LTYPE_CODE(L_CODE), .STYPE_CODE(S_CODE)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .itype_i(itype_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
        .misalign_o(misalign_o), .fault_o(fault_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .dbg_state_o(dbg_state_o)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected outputs for the current cycle
    logic        exp_busy = 0, exp_done = 0, exp_req = 0, exp_we = 0;
    logic        exp_mis = 0, exp_fault = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0, exp_rdata = 0;
    logic [3:0]  exp_be = 0;
    logic [31:0] rdata_m = 0;

    // Observations of the last access
    int          cap_req, cap_done;
    logic        cap_fault, cap_mis, cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", busy_o, exp_busy);
        chk("done", done_o, exp_done);
        chk("rdata", rdata_o, exp_rdata);
        chk("misalign", misalign_o, exp_mis);
        chk("fault", fault_o, exp_fault);
        chk("mem_req", mem_req_o, exp_req);
        chk("mem_we", mem_we_o, exp_we);
        chk("mem_addr", mem_addr_o, exp_addr);
        chk("mem_be", mem_be_o, exp_be);
        chk("mem_wdata", mem_wdata_o, exp_wdata);
    end

    task automatic set_exp(input logic b, input logic d, input logic r, input logic w,
                           input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                           input logic m, input logic f);
        exp_busy = b; exp_done = d; exp_req = r; exp_we = w;
        exp_addr = a; exp_be = be; exp_wdata = wd;
        exp_mis = m; exp_fault = f; exp_rdata = rdata_m;
    endtask

    task automatic sample();
        if (mem_req_o) begin
            cap_req++;
            if (cap_req == 1) begin
                cap_be = mem_be_o; cap_wdata = mem_wdata_o; cap_we = mem_we_o;
            end
        end
        if (done_o) begin
            cap_done++; cap_fault = fault_o; cap_mis = misalign_o;
        end
    endtask

    task automatic junk_inputs();
        start_i  = 1'($urandom_range(0, 1));
        itype_i  = 5'($urandom);
        funct3_i = 3'($urandom);
        addr_i   = $urandom;
        wdata_i  = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start_i = 1'($urandom_range(0, 1));
            itype_i = 5'($urandom_range(16, 31));
            @(posedge clk);
            #1 sample();
        end
        start_i = 1'b0;
    endtask

    // ack_at: REQ cycle (1-based) on which the responder acks; outside 1..TO means never.
    task automatic do_access(input logic [4:0] it, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int ack_at, input logic [31:0] rword);
        logic is_l, is_s, f3ok, mis, timed;
        int sz, n;
        logic [31:0] be_e, wd_e, rd_e, sh;
        is_l = (it == L_CODE);
        is_s = !is_l && (it == S_CODE);
        f3ok = is_l ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis  = f3ok && (a % sz != 0);
        be_e = (sz == 4) ? 32'hF : ((sz == 2 ? 32'h3 : 32'h1) << (a % 4));
        wd_e = !is_s ? 0 : (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
               (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        sh   = rword >> (8 * (a % 4));
        if (sz == 4) rd_e = rword;
        else if (sz == 2) rd_e = (f3 == 3'd1 && sh[15]) ? (sh & 32'hFFFF) | 32'hFFFF0000 : sh & 32'hFFFF;
        else rd_e = (f3 == 3'd0 && sh[7]) ? (sh & 32'hFF) | 32'hFFFFFF00 : sh & 32'hFF;
        timed = !(ack_at >= 1 && ack_at <= TO);
        n = timed ? TO : ack_at;
        cap_req = 0; cap_done = 0; cap_fault = 0; cap_mis = 0;
        cap_we = 0; cap_be = 0; cap_wdata = 0;

        start_i = 1'b1; itype_i = it; funct3_i = f3; addr_i = a; wdata_i = wd;
        @(posedge clk);
        if (!is_l && !is_s) begin
            #1 sample();
            start_i = 1'b0;
        end else if (!f3ok || mis) begin
            rdata_m = 0;
            set_exp(1, 1, 0, 0, 0, 0, 0, mis, !f3ok);
            #1 sample();
            junk_inputs();
            @(posedge clk);
            set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1 sample();
            start_i = 1'b0;
        end else begin
            set_exp(1, 0, 1, is_s, {a[31:2], 2'b00}, be_e[3:0], wd_e, 0, 0);
            #1 sample();
            for (int i = 1; i <= n; i++) begin
                junk_inputs();
                mem_ack_i   = (i == ack_at);
                mem_rdata_i = (i == ack_at) ? rword : $urandom;
                @(posedge clk);
                if (i == n) begin
                    rdata_m = (is_l && !timed) ? rd_e : 0;
                    set_exp(1, 1, 0, 0, 0, 0, 0, 0, timed);
                end
                #1 sample();
            end
            mem_ack_i = 1'b0;
            junk_inputs();
            @(posedge clk);
            set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1 sample();
            start_i = 1'b0;
        end
    endtask

    initial begin
        int it_sel, ack_at;
        logic [4:0]  it;
        logic [2:0]  f3;
        logic [31:0] a;
        reset = 1'b0; start_i = 0; itype_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
        mem_ack_i = 0; mem_rdata_i = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Accepted on the very first edge after reset release
        do_access(L_CODE, 3'd2, 32'h01000010, 0, 2, 32'hDEADBEEF);
        chk("lw_rdata", rdata_o, 32'hDEADBEEF);
        chk("lw_be", cap_be, 4'b1111);
        chk("lw_done_cycles", cap_done, 1);
        chk("lw_req_cycles", cap_req, 2);

        do_access(L_CODE, 3'd0, 32'h01000003, 0, 1, 32'h80000000);
        chk("lb_rdata", rdata_o, 32'hFFFFFF80);
        do_access(L_CODE, 3'd4, 32'h01000003, 0, 1, 32'h80000000);
        chk("lbu_rdata", rdata_o, 32'h00000080);

        do_access(S_CODE, 3'd1, 32'h01000002, 32'h0000ABCD, 3, 0);
        chk("sh_we", cap_we, 1);
        chk("sh_be", cap_be, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'hABCDABCD);
        chk("sh_rdata", rdata_o, 0);

        do_access(L_CODE, 3'd2, 32'h01000001, 0, 1, 0);
        chk("mis_req_cycles", cap_req, 0);
        chk("mis_flag", cap_mis, 1);
        chk("mis_done_cycles", cap_done, 1);

        do_access(S_CODE, 3'd2, 32'h01000020, 32'h12345678, 0, 0);
        chk("to_req_cycles", cap_req, 16);
        chk("to_fault", cap_fault, 1);
        do_access(S_CODE, 3'd2, 32'h01000020, 32'h12345678, 16, 0);
        chk("ack16_req_cycles", cap_req, 16);
        chk("ack16_fault", cap_fault, 0);

        do_access(L_CODE, 3'd3, 32'h01000000, 0, 1, 0);
        chk("ill_fault", cap_fault, 1);
        chk("ill_req_cycles", cap_req, 0);

        do_access(5'b10101, 3'd2, 32'h01000000, 0, 1, 0);
        chk("nontype_done_cycles", cap_done, 0);

        // Reset in the middle of a pending load
        start_i = 1; itype_i = L_CODE; funct3_i = 3'd2; addr_i = 32'h00000100;
        @(posedge clk);
        set_exp(1, 0, 1, 0, 32'h00000100, 4'hF, 0, 0, 0);
        #1 start_i = 0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        rdata_m = 0;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_req", mem_req_o, 0);
        chk("rst_busy", busy_o, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        cap_req = 0; cap_done = 0;
        idle_cycles(3);
        chk("rst_no_done", cap_done, 0);
        do_access(L_CODE, 3'd5, 32'h00000102, 0, 2, 32'h8001F00F);
        chk("post_rst_lhu", rdata_o, 32'h00008001);

        // Randomized accesses
        for (int k = 0; k < 250; k++) begin
            it_sel = $urandom_range(0, 9);
            it = (it_sel < 4) ? L_CODE : (it_sel < 8) ? S_CODE : 5'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~((f3[1:0] == 2'd2) ? 32'h3 : (f3[1:0] == 2'd1) ? 32'h1 : 32'h0);
            ack_at = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 4);
            do_access(it, f3, a, $urandom, ack_at, $urandom);
            idle_cycles($urandom_range(0, 2));
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_master.md
LOAD_STORE_MASTER -- requirements
Module: load_store_master

Interface
REQ-001 Parameter TIMEOUT, default 16, is the number of REQ-state cycles without mem_ack_i before the access faults.
REQ-002 Parameter LTYPE_CODE, default the shared `LTYPE value, is the itype_i code for loads.
REQ-003 Parameter STYPE_CODE, default the shared `STYPE value, is the itype_i code for stores.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start_i  in  1  pipeline requests an access this cycle.
REQ-007 itype_i  in  5  instruction type (LTYPE_CODE or STYPE_CODE).
REQ-008 funct3_i  in  3  access width/sign (ir[14:12]).
REQ-009 addr_i  in  32  effective byte address.
REQ-010 wdata_i  in  32  store data, right-justified.
REQ-011 busy_o  out  1  access in progress; start_i ignored.
REQ-012 done_o  out  1  one-cycle completion pulse.
REQ-013 rdata_o  out  32  extended load result, valid with done_o.
REQ-014 misalign_o / fault_o  out  1 each  error flags, valid with done_o.
REQ-015 mem_req_o  out  1  request to memory responder.
REQ-016 mem_we_o  out  1  1 = write.
REQ-017 mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-018 mem_be_o  out  4  byte enables.
REQ-019 mem_wdata_o  out  32  lane-positioned write data.
REQ-020 mem_ack_i  in  1  responder completes the access this cycle.
REQ-021 mem_rdata_i  in  32  read word, valid with mem_ack_i.

Function
REQ-022 States: IDLE, REQ, DONE; busy_o=1 in REQ and DONE.
REQ-023 IDLE + start_i + valid access -> REQ; mem_* outputs registered from the inputs captured at start_i.
REQ-024 Valid: itype_i=LTYPE_CODE with funct3 in {0,1,2,4,5}, or itype_i=STYPE_CODE with funct3 in {0,1,2}; any other itype_i with start_i is ignored (no state change, no done_o).
REQ-025 Load/store with an illegal funct3 -> DONE with fault_o=1, no mem_req_o.
REQ-026 Halfword with addr[0]=1, or word with addr[1:0]!=0 -> DONE with misalign_o=1, no mem_req_o.
REQ-027 mem_req_o=1 and mem_addr_o/mem_be_o/mem_we_o/mem_wdata_o held stable for every REQ cycle.
REQ-028 REQ + mem_ack_i -> DONE next cycle; mem_req_o drops in that same edge.
REQ-029 Wait counter clears on REQ entry and increments each REQ cycle without ack; reaching TIMEOUT-1 without ack -> DONE with fault_o=1; ack on that same cycle wins (no fault).
REQ-030 DONE lasts exactly one cycle: done_o=1, then -> IDLE; earliest back-to-back start is accepted in the following IDLE cycle.
REQ-031 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads use the same mask.
REQ-032 Store data: byte replicated to all four lanes, half replicated to both halves, word unchanged.
REQ-033 Load extraction selects the byte/half at addr[1:0] from mem_rdata_i; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-034 rdata_o is updated only on a completing load; it holds its value otherwise and is 0 for stores and errors.
REQ-035 misalign_o and fault_o are meaningful only while done_o=1 and are 0 at all other times.

Reset
REQ-036 reset low asynchronously forces IDLE, counter 0, and all outputs 0, including mid-REQ; the pending access is abandoned with no done_o.
REQ-037 The first start_i is accepted on the first rising edge after reset deasserts.

Verification
REQ-038 LW addr 0x01000010 with ack after 2 cycles, mem_rdata_i 0xDEADBEEF -> be 4'b1111, rdata_o 0xDEADBEEF, done_o one cycle.
REQ-039 LB addr 0x01000003, rdata 0x80000000 -> rdata_o 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 SH addr 0x01000002 wdata 0x0000ABCD -> mem_we_o 1, be 4'b1100, mem_wdata_o 0xABCDABCD.
REQ-041 LW addr 0x01000001 -> no mem_req_o, done_o with misalign_o 1 on the cycle after start.
REQ-042 Store with no ack, TIMEOUT 16 -> fault_o with done_o after 16 REQ cycles; a second run with ack on cycle 16 -> no fault.
REQ-043 reset low during REQ -> mem_req_o 0 immediately, no done_o, and the next start_i works normally.
